theta_tracker: RTL and testbench
================================

Name: theta_tracker

Overview:
- Derives the display's angular position from a once-per-revolution hall-effect index pulse.
- Measures the rotation period in clk_in cycles and divides each revolution into 2^THETA_W equal slices.
- Drives the theta input of the frame-selection stage immediately downstream.
- Reports lock status so downstream stages can blank output while rotation is unstable.

Parameters:
- THETA_W, 8, angular resolution in bits; 2^THETA_W slices per revolution.
- PERIOD_W, 32, width of the period counter and of period_out.
- MIN_PERIOD, 4096, shortest accepted revolution in cycles; shorter index edges are glitches. Must be >= 2^THETA_W.
- MAX_PERIOD, 2^31-1, cycles without an accepted index before lock is dropped.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-low reset
- hall_in  input  1  raw hall sensor; asynchronous; rising edge marks theta = 0
- theta  output  THETA_W  current angular slice
- theta_step  output  1  one-cycle pulse whenever theta changes or is re-zeroed
- locked  output  1  high while theta is derived from a valid period measurement
- period_out  output  PERIOD_W  last accepted revolution period in cycles

Behaviour:
- Reset (rst_in low, asynchronous):
  - theta = 0, theta_step = 0, locked = 0, period_out = 0.
  - Internal counters cleared; state = UNLOCKED.
  - The synchronizer flops clear to 0.
- Synchronizer and edge detect:
  - hall_in passes through 2 flops, then one edge register.
  - An index event is a synchronized 0->1 transition.
  - hall_in sampled high at edge k produces the index event at edge k+2. Its effects are visible on outputs after edge k+3.
- Cycle counter cnt:
  - Increments every cycle and saturates at MAX_PERIOD.
  - Cleared on every accepted index event.
- Index acceptance:
  - Accepted only if cnt >= MIN_PERIOD, or if state = UNLOCKED.
  - Rejected events change nothing; cnt keeps counting.
- State machine:
  - UNLOCKED:
    - theta held at 0, locked = 0, no theta_step.
    - Accepted index -> ACQUIRE, cnt cleared.
  - ACQUIRE:
    - Outputs as in UNLOCKED.
    - Accepted index -> LOCKED; period_out = cnt + 1 at that event, slice_len = period_out >> THETA_W; theta = 0; theta_step pulses.
    - cnt reaching MAX_PERIOD -> UNLOCKED.
  - LOCKED:
    - locked = 1.
    - A slice counter counts 0..slice_len-1. On wrap, theta increments and theta_step pulses.
    - theta saturates at 2^THETA_W-1 and does not wrap; it holds until the next index. The floor remainder of the division is absorbed here.
    - Accepted index -> period_out and slice_len updated as in ACQUIRE; theta = 0; slice counter = 0; theta_step pulses.
    - cnt reaching MAX_PERIOD -> UNLOCKED; theta = 0 and locked = 0 on the next edge; no theta_step.
- Arithmetic:
  - slice_len is a pure shift; no divider.
  - slice_len >= 1 is guaranteed by the MIN_PERIOD constraint.
  - New slice_len applies from the first slice after the index that produced it.
- Simultaneous events:
  - An accepted index in the same cycle as a slice wrap: the index wins. theta = 0, with exactly one theta_step.
  - An index in the same cycle as a timeout: the index is accepted and the state machine goes to ACQUIRE, not LOCKED.
- Reset asserted mid-revolution returns all outputs to reset values immediately. Re-acquisition needs two new accepted edges.

Test Plan:
- Pulses every 25600 cycles, MIN_PERIOD 4096 -> locked rises 3 cycles after the 2nd pulse. period_out = 25600. theta steps every 100 cycles, reaching 255 at 25500 cycles after the index.
- Pulses at period 25700 -> slice_len = 100. theta holds 255 for 200 cycles, then returns to 0 with one theta_step on the index.
- While locked, extra pulse 1000 cycles after an index -> ignored. theta continues 0..10 unchanged; period_out unchanged.
- Period changes 25600 -> 12800 -> the revolution after the shorter index uses slice_len = 50 and period_out = 12800.
- MAX_PERIOD set to 50000, pulses stopped -> locked falls and theta = 0 at 50000 cycles after the last index. The next single pulse does not relock; the second pulse does.
- rst_in pulsed low mid-revolution with theta = 137 -> theta = 0, locked = 0, period_out = 0 asynchronously. Lock returns only after two further pulses.

Source files
------------

// File: rtl/theta_tracker.sv
// -----------------------------------------------------------------------------
// theta_tracker
//
// Derives the angular position of a rotating display from a once-per-revolution
// hall-effect index pulse. The revolution period is measured in clock cycles
// and each revolution is divided into 2^THETA_W equal slices by a pure shift.
//
// Ports:
//   clk_in      system clock
//   rst_in      asynchronous active-low reset
//   hall_in     raw hall sensor (asynchronous); rising edge marks theta = 0
//   theta       current angular slice
//   theta_step  one-cycle pulse whenever theta changes or is re-zeroed
//   locked      high while theta is derived from a valid period measurement
//   period_out  last accepted revolution period in cycles
// -----------------------------------------------------------------------------
module theta_tracker #(
   parameter int          THETA_W    = 8,
   parameter int          PERIOD_W   = 32,
   parameter int unsigned MIN_PERIOD = 4096,
   parameter int unsigned MAX_PERIOD = 32'h7FFF_FFFF
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                hall_in,
   output logic [THETA_W-1:0]  theta,
   output logic                theta_step,
   output logic                locked,
   output logic [PERIOD_W-1:0] period_out
);

   localparam logic [1:0] S_UNLOCKED = 2'd0;
   localparam logic [1:0] S_ACQUIRE  = 2'd1;
   localparam logic [1:0] S_LOCKED   = 2'd2;

   localparam logic [PERIOD_W-1:0] L_MIN       = PERIOD_W'(MIN_PERIOD);
   localparam logic [PERIOD_W-1:0] L_MAX       = PERIOD_W'(MAX_PERIOD);
   localparam logic [PERIOD_W-1:0] L_ONE       = PERIOD_W'(1);
   localparam logic [THETA_W-1:0]  L_THETA_MAX = '1;

   // Synchronizer, edge register and registered index event
   logic                r_sync1;
   logic                r_sync2;
   logic                r_hall_d;
   logic                r_index;

   logic [PERIOD_W-1:0] r_cnt;
   logic [1:0]          r_state;
   logic [PERIOD_W-1:0] r_period;
   logic [PERIOD_W-1:0] r_slice_len;
   logic [PERIOD_W-1:0] r_slice_cnt;
   logic [THETA_W-1:0]  r_theta;
   logic                r_step;

   logic                w_timeout;
   logic                w_accept;
   logic                w_wrap;
   logic [PERIOD_W-1:0] w_period_new;
   logic [PERIOD_W-1:0] w_slice_len_new;

   always_comb begin
      w_timeout       = (r_cnt == L_MAX);
      // Short index intervals are glitches, except the very first edge that
      // starts a measurement from the unlocked state.
      w_accept        = r_index && ((r_state == S_UNLOCKED) || (r_cnt >= L_MIN));
      w_wrap          = (r_slice_cnt == (r_slice_len - L_ONE));
      // cnt was cleared at the previous accepted index, so the period is cnt+1
      w_period_new    = r_cnt + L_ONE;
      w_slice_len_new = w_period_new >> THETA_W;
   end

   // Two-flop synchronizer plus edge register; the index event itself is
   // registered so the state machine sees a clean one-cycle pulse.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_hall_d <= 1'b0;
         r_index  <= 1'b0;
      end else begin
         r_sync1  <= hall_in;
         r_sync2  <= r_sync1;
         r_hall_d <= r_sync2;
         r_index  <= r_sync2 & ~r_hall_d;
      end
   end

   // Free-running revolution counter, saturating so timeout stays asserted
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= '0;
      end else if (!w_timeout) begin
         r_cnt <= r_cnt + L_ONE;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state     <= S_UNLOCKED;
         r_period    <= '0;
         r_slice_len <= '0;
         r_slice_cnt <= '0;
         r_theta     <= '0;
         r_step      <= 1'b0;
      end else begin
         r_step <= 1'b0;
         case (r_state)
            S_UNLOCKED: begin
               r_theta <= '0;
               if (w_accept) begin
                  r_state <= S_ACQUIRE;
               end
            end

            S_ACQUIRE: begin
               r_theta <= '0;
               if (w_accept && !w_timeout) begin
                  r_state     <= S_LOCKED;
                  r_period    <= w_period_new;
                  r_slice_len <= w_slice_len_new;
                  r_slice_cnt <= '0;
                  r_step      <= 1'b1;
               end else if (w_accept) begin
                  // Index coinciding with timeout restarts the measurement
                  r_state <= S_ACQUIRE;
               end else if (w_timeout) begin
                  r_state <= S_UNLOCKED;
               end
            end

            S_LOCKED: begin
               if (w_accept && w_timeout) begin
                  r_state <= S_ACQUIRE;
                  r_theta <= '0;
               end else if (w_accept) begin
                  // Index takes priority over a coincident slice wrap
                  r_period    <= w_period_new;
                  r_slice_len <= w_slice_len_new;
                  r_slice_cnt <= '0;
                  r_theta     <= '0;
                  r_step      <= 1'b1;
               end else if (w_timeout) begin
                  r_state <= S_UNLOCKED;
                  r_theta <= '0;
               end else if (w_wrap) begin
                  r_slice_cnt <= '0;
                  // Saturate: the division remainder is absorbed at the top slice
                  if (r_theta != L_THETA_MAX) begin
                     r_theta <= r_theta + 1'b1;
                     r_step  <= 1'b1;
                  end
               end else begin
                  r_slice_cnt <= r_slice_cnt + L_ONE;
               end
            end

            default: begin
               r_state <= S_UNLOCKED;
               r_theta <= '0;
            end
         endcase
      end
   end

   assign theta      = r_theta;
   assign theta_step = r_step;
   assign locked     = (r_state == S_LOCKED);
   assign period_out = r_period;

endmodule

// File: tb/tb_theta_tracker.sv
// -----------------------------------------------------------------------------
// tb_theta_tracker
//
// Drives hall pulses (fixed and randomized periods, glitches, timeouts and a
// mid-revolution reset) into theta_tracker and compares every output each
// cycle against an arithmetic reference model: theta is derived as
// min(cycles_since_index / slice_len, 2^THETA_W-1) rather than by counting.
// Parameters are scaled down so the whole run stays short.
// -----------------------------------------------------------------------------
module tb_theta_tracker;

   localparam int THETA_W  = 8;
   localparam int PERIOD_W = 32;
   localparam int MINP     = 512;
   localparam int MAXP     = 5000;
   localparam int TMAX     = (1 << THETA_W) - 1;

   logic                clk_in;
   logic                rst_in;
   logic                hall_in;
   logic [THETA_W-1:0]  theta;
   logic                theta_step;
   logic                locked;
   logic [PERIOD_W-1:0] period_out;

   theta_tracker #(
      .THETA_W    (THETA_W),
      .PERIOD_W   (PERIOD_W),
      .MIN_PERIOD (MINP),
      .MAX_PERIOD (MAXP)
   ) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .hall_in    (hall_in),
      .theta      (theta),
      .theta_step (theta_step),
      .locked     (locked),
      .period_out (period_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit h_hist [131072];
   int j        = 0;   // number of clock edges taken out of reset
   int rst_edge = 0;   // samples at or before this edge read as 0
   int base     = 0;   // edge at which the cycle count was last cleared
   int lock_e   = 0;   // edge of the index that started the current revolution
   int m_state  = 0;   // 0 unlocked, 1 acquire, 2 locked
   int m_period = 0;
   int m_len    = 0;
   int e_theta  = 0;
   int e_step   = 0;
   int e_locked = 0;
   int e_period = 0;

   function automatic bit hist(input int k);
      if (k <= rst_edge || k < 0) return 1'b0;
      return h_hist[k];
   endfunction

   initial begin
      forever begin
         @(posedge clk_in);
         if (!rst_in) begin
            m_state = 0; m_period = 0; m_len = 0;
            base = j; rst_edge = j;
            e_theta = 0; e_step = 0; e_locked = 0; e_period = 0;
         end else begin
            int  cnt_b, n, q;
            bit  idx, acc, tmo;
            j++;
            h_hist[j] = hall_in;
            idx   = hist(j - 3) && !hist(j - 4);
            cnt_b = j - 1 - base;
            if (cnt_b > MAXP) cnt_b = MAXP;
            acc = idx && (m_state == 0 || cnt_b >= MINP);
            tmo = (cnt_b == MAXP);
            if (acc) base = j;
            case (m_state)
               0: if (acc) m_state = 1;
               default: begin
                  if (acc && !tmo) begin
                     m_state  = 2;
                     m_period = cnt_b + 1;
                     m_len    = m_period / (1 << THETA_W);
                     lock_e   = j;
                  end else if (acc) begin
                     m_state = 1;
                  end else if (tmo) begin
                     m_state = 0;
                  end
               end
            endcase
            if (m_state == 2) begin
               n = j - lock_e;
               q = n / m_len;
               e_theta  = (q > TMAX) ? TMAX : q;
               e_step   = (n == 0 || ((n % m_len) == 0 && q <= TMAX)) ? 1 : 0;
               e_locked = 1;
            end else begin
               e_theta = 0; e_step = 0; e_locked = 0;
            end
            e_period = m_period;
         end
      end
   end

   // Per-cycle comparison away from the active edge
   initial begin
      forever begin
         @(negedge clk_in);
         chk("theta",      theta,      e_theta);
         chk("theta_step", theta_step, e_step);
         chk("locked",     locked,     e_locked);
         chk("period_out", period_out, e_period);
      end
   end

   // ---------------- stimulus ----------------
   task automatic rev(input int period, input int width);
      $display("pulse period=%0d width=%0d at %0t", period, width, $time);
      hall_in = 1'b1;
      repeat (width) @(negedge clk_in);
      hall_in = 1'b0;
      repeat (period - width) @(negedge clk_in);
   endtask

   task automatic rev_glitch(input int period, input int gap);
      $display("pulse period=%0d glitch at +%0d at %0t", period, gap, $time);
      hall_in = 1'b1;
      repeat (4) @(negedge clk_in);
      hall_in = 1'b0;
      repeat (gap - 4) @(negedge clk_in);
      hall_in = 1'b1;
      repeat (3) @(negedge clk_in);
      hall_in = 1'b0;
      repeat (period - gap - 3) @(negedge clk_in);
   endtask

   initial begin
      rst_in  = 1'b0;
      hall_in = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("rst_theta",  theta,      0);
      chk("rst_locked", locked,     0);
      chk("rst_period", period_out, 0);
      rst_in = 1'b1;
      repeat (5) @(negedge clk_in);

      // Lock at period 2560; locked rises 3 edges after the 2nd pulse is sampled
      rev(2560, 5);
      hall_in = 1'b1;
      repeat (3) @(negedge clk_in);
      chk("lock_early", locked, 0);
      @(negedge clk_in);
      chk("lock_rise", locked, 1);
      hall_in = 1'b0;
      repeat (2560 - 4) @(negedge clk_in);
      rev(2560, 7);
      rev(2560, 3);
      chk("period_2560", period_out, 2560);

      // Period with remainder: theta saturates and holds at the top
      repeat (3) rev(2570, 6);
      chk("period_2570", period_out, 2570);

      // Glitch shortly after an index is ignored
      rev_glitch(2570, 100);
      rev(2570, 5);
      chk("glitch_period", period_out, 2570);

      // Shorter period
      repeat (3) rev(1280, 4);
      chk("period_1280", period_out, 1280);

      // Stop pulses: timeout drops lock; one pulse is not enough to relock
      repeat (MAXP + 100) @(negedge clk_in);
      chk("timeout_locked", locked, 0);
      chk("timeout_theta",  theta,  0);
      rev(2560, 5);
      chk("single_no_lock", locked, 0);
      rev(2560, 5);
      chk("relock", locked, 1);

      // Randomized revolutions with occasional glitches
      for (int i = 0; i < 8; i++) begin
         int p;
         p = $urandom_range(3000, 600);
         if ($urandom_range(3, 0) == 0)
            rev_glitch(p, $urandom_range(400, 20));
         else
            rev(p, $urandom_range(20, 1));
      end

      // Mid-revolution reset at theta == 137
      rev(2560, 5);
      rev(2560, 5);
      hall_in = 1'b1;
      repeat (4) @(negedge clk_in);
      hall_in = 1'b0;
      for (int i = 0; i < 3000 && theta != 8'd137; i++) @(negedge clk_in);
      chk("theta_137", theta, 137);
      #2 rst_in = 1'b0;
      #1;
      chk("arst_theta",  theta,      0);
      chk("arst_locked", locked,     0);
      chk("arst_period", period_out, 0);
      chk("arst_step",   theta_step, 0);
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;
      repeat (10) @(negedge clk_in);
      rev(2560, 5);
      chk("post_rst_one", locked, 0);
      rev(2560, 5);
      chk("post_rst_two", locked, 1);
      chk("post_rst_period", period_out, 2560);

      repeat (20) @(negedge clk_in);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
